// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding, event layout and game-key map
// for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

  localparam int EV_W = 10;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_FIRE  = 4;
  localparam int KEY_START = 5;
  localparam int KEY_BACK  = 6;
  localparam int KEY_PAUSE = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  // Keyboard housekeeping replies (BAT, echo, ack, errors) carry no key data.
  function automatic logic is_discard(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = '0;
    case ({ext, code})
      9'h01D, 9'h175: m[KEY_UP]    = 1'b1;
      9'h01B, 9'h172: m[KEY_DOWN]  = 1'b1;
      9'h01C, 9'h16B: m[KEY_LEFT]  = 1'b1;
      9'h023, 9'h174: m[KEY_RIGHT] = 1'b1;
      9'h029:         m[KEY_FIRE]  = 1'b1;
      9'h05A, 9'h15A: m[KEY_START] = 1'b1;
      9'h076:         m[KEY_BACK]  = 1'b1;
      9'h04D:         m[KEY_PAUSE] = 1'b1;
      default:        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO: head always presents the oldest entry; a pop while
// full frees a slot for a push in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [EV_W-1:0] push_data,
  input  logic            pop,
  output logic [EV_W-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [EV_W-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 prefix decoder: assembles E0/F0/E1 sequences into key events, queues
// them and tracks held game keys. Define PS2_TYPEMATIC_FILTER_EN to drop repeated makes.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] keys_held,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;
  logic [2:0]      skip_cnt, skip_nxt;
  logic            done;
  logic            pause_hit;
  event_t          ev_new;
  logic [7:0]      mask;
  logic [7:0]      held;
  logic            pause_pulse;
  logic            push;
  logic            full;
  logic            empty;
  logic [EV_W-1:0] head_raw;
  event_t          head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = '0;
    skip_nxt  = skip_cnt;
    done      = 1'b0;
    pause_hit = 1'b0;
    ev_new    = '{ext: 1'b0, brk: 1'b0, code: code_in};
    if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code_in == CODE_E0) state_nxt = ST_EXT;
          else if (code_in == CODE_F0) state_nxt = ST_BRK;
          else if (code_in == CODE_E1) begin
            state_nxt = ST_SKIP;
            skip_nxt  = 3'd7;
          end else if (!is_discard(code_in)) done = 1'b1;
        end
        ST_EXT: begin
          if (code_in == CODE_F0) state_nxt = ST_EXTBRK;
          else if (code_in != CODE_E0) begin
            done       = 1'b1;
            ev_new.ext = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          // A second prefix inside a break sequence is malformed: drop it all.
          state_nxt = ST_IDLE;
          if (code_in != CODE_E0 && code_in != CODE_F0) begin
            done       = 1'b1;
            ev_new.brk = 1'b1;
            ev_new.ext = (state == ST_EXTBRK);
          end
        end
        ST_SKIP: begin
          skip_nxt = skip_cnt - 1'b1;
          if (skip_cnt == 3'd1) begin
            done        = 1'b1;
            pause_hit   = 1'b1;
            ev_new.code = CODE_E1;
            state_nxt   = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TMO_LAST) state_nxt = ST_IDLE;
      else tmo_nxt = tmo_cnt + 1'b1;
    end
  end

  assign mask = key_mask(ev_new.ext, ev_new.code);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign push = done && !(!ev_new.brk && |(mask & held));
`else
  assign push = done;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held        <= '0;
      pause_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (done) held <= ev_new.brk ? (held & ~mask) : (held | mask);
      pause_pulse <= pause_hit;
      if (push && full && !ev_ready) overflow <= 1'b1;
      else if (clr_ovf)              overflow <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(ev_new),
    .pop      (ev_ready),
    .head     (head_raw),
    .full     (full),
    .empty    (empty)
  );

  assign head      = event_t'(head_raw);
  assign ev_valid  = !empty;
  assign ev_code   = ev_valid ? head.code : 8'h00;
  assign ev_ext    = ev_valid && head.ext;
  assign ev_brk    = ev_valid && head.brk;
  assign keys_held = held | {pause_pulse, 7'b0};

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios followed by
// random byte traffic against a sequence-level reference model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int EXP_FIRE_EVENTS = 1;
`else
  localparam int EXP_FIRE_EVENTS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] keys_held;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  ps2_scancode_decoder #(
    .DEPTH      (DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_brk    (ev_brk),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .keys_held (keys_held),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes of the sequence in progress, queued events {ext,brk,code}.
  logic [7:0] pend [$];
  logic [9:0] mq [$];
  logic [7:0] m_held = '0;
  logic       m_pulse = 1'b0;
  logic       m_ovf = 1'b0;
  int         gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int key_index(input logic ext, input logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        8'h29: return 4;
        8'h5A: return 5;
        8'h76: return 6;
        8'h4D: return 7;
        default: return -1;
      endcase
    end
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      8'h5A: return 5;
      default: return -1;
    endcase
  endfunction

  // Interpret the whole pending sequence after appending one byte.
  task automatic feed_byte(input logic [7:0] b, output logic have, output logic [9:0] ev,
                           output logic pz);
    logic brk_seen;
    logic ext;
    have = 1'b0;
    ev   = '0;
    pz   = 1'b0;
    if (pend.size() == 0) begin
      if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) have = 1'b0;
      else if (b inside {8'hE0, 8'hF0, 8'hE1}) pend.push_back(b);
      else begin
        have = 1'b1;
        ev   = {2'b00, b};
      end
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        have = 1'b1;
        ev   = {2'b00, 8'hE1};
        pz   = 1'b1;
        pend.delete();
      end
    end else begin
      brk_seen = (pend[pend.size()-1] == 8'hF0);
      ext      = (pend[0] == 8'hE0);
      if (b == 8'hE0 || b == 8'hF0) begin
        if (brk_seen) pend.delete();
        else pend.push_back(b);
      end else begin
        have = 1'b1;
        ev   = {ext, brk_seen, b};
        pend.delete();
      end
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
    logic       have, pz, enq, drop;
    logic [9:0] ev;
    int         idx;
    have = 1'b0;
    pz   = 1'b0;
    ev   = '0;
    if (v) begin
      if (gap >= TMO) pend.delete();
      feed_byte(b, have, ev, pz);
      gap = 0;
    end else begin
      gap++;
    end
    idx = have ? key_index(ev[9], ev[7:0]) : -1;
    enq = have;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (have && !ev[8] && idx >= 0 && m_held[idx]) enq = 1'b0;
`endif
    if (idx >= 0) m_held[idx] = !ev[8];
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    drop = 1'b0;
    if (enq) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else drop = 1'b1;
    end
    if (clr)  m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_pulse = pz;
  endtask

  task automatic compare_all();
    logic [9:0] h;
    check("ev_valid", ev_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      h = mq[0];
      check("ev_code", ev_code, h[7:0]);
      check("ev_ext", ev_ext, h[9]);
      check("ev_brk", ev_brk, h[8]);
    end
    check("keys_held", keys_held, m_held | {m_pulse, 7'b0});
    check("overflow", overflow, m_ovf);
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
    @(negedge clk);
    code_valid = v;
    code_in    = b;
    ev_ready   = rdy;
    clr_ovf    = clr;
    model_step(v, b, rdy, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    code_valid = 1'b0;
    ev_ready   = 1'b0;
    clr_ovf    = 1'b0;
    #1 rst = 1'b1;
    #1;
    pend.delete();
    mq.delete();
    m_held  = '0;
    m_pulse = 1'b0;
    m_ovf   = 1'b0;
    gap     = 0;
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_fields", {ev_code, ev_ext, ev_brk}, 10'h000);
    check("rst_keys_held", keys_held, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] pool [16];
    logic [7:0] b;
    int         pulses;
    int         n;
    int         r;

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    pool      = '{8'hE0, 8'hF0, 8'hE1, 8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C,
                  8'h6B, 8'h23, 8'h74, 8'h29, 8'h5A, 8'h76, 8'h4D, 8'hAA};

    do_reset();

    // W make then break.
    step(1'b1, 8'h1D, 1'b0, 1'b0);
    check("w_make_code", {ev_code, ev_ext, ev_brk}, {8'h1D, 2'b00});
    check("w_make_bit", keys_held[0], 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h1D, 1'b0, 1'b0);
    check("w_break_code", {ev_code, ev_ext, ev_brk}, {8'h1D, 2'b01});
    check("w_break_bit", keys_held[0], 1'b0);
    drain();

    // Extended right arrow make then break.
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'h74, 1'b0, 1'b0);
    check("rarrow_make", {ev_code, ev_ext, ev_brk}, {8'h74, 2'b10});
    check("rarrow_make_bit", keys_held[3], 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h74, 1'b0, 1'b0);
    check("rarrow_break", {ev_code, ev_ext, ev_brk}, {8'h74, 2'b11});
    check("rarrow_break_bit", keys_held[3], 1'b0);
    drain();

    // Pause sequence: one event, one-cycle pulse, then back to plain decoding.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pause_seq[i], 1'b0, 1'b0);
      if (keys_held[7]) pulses++;
    end
    check("pause_event", {ev_code, ev_ext, ev_brk}, {8'hE1, 2'b00});
    step(1'b0, 8'h00, 1'b0, 1'b0);
    if (keys_held[7]) pulses++;
    check("pause_pulse_cycles", pulses, 1);
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    check("after_pause_idle", {ev_code, ev_ext, ev_brk}, {8'h1C, 2'b00});
    drain();

    // Timeout boundary: a gap of TMO-1 idle cycles keeps the prefix, TMO drops it.
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TMO - 1) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    check("tmo_kept_ext", {ev_code, ev_ext}, {8'h1C, 1'b1});
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TMO) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    check("tmo_dropped_ext", {ev_code, ev_ext}, {8'h1C, 1'b0});
    drain();

    // Overflow: nine makes into eight slots, pop in order, then clear.
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", ev_code, 8'(8'h11 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("ovf_drained", ev_valid, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 1'b0);

    // Clear coinciding with a new drop, then push+pop while full.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'h48, 1'b0, 1'b1);
    check("ovf_clr_collide", overflow, 1'b1);
    step(1'b1, 8'h49, 1'b1, 1'b0);
    check("full_push_pop_head", ev_code, 8'h41);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    drain();
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("empty_push_pop", {ev_valid, ev_code}, {1'b1, 8'h33});
    drain();

    // Typematic repeats of fire.
    repeat (3) step(1'b1, 8'h29, 1'b0, 1'b0);
    check("fire_held", keys_held[4], 1'b1);
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (ev_valid) n++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("fire_event_count", n, EXP_FIRE_EVENTS);

    // Reset in the middle of a prefix with events queued.
    step(1'b1, 8'h1D, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    check("rst_mid_seq", {ev_code, ev_ext, ev_brk, keys_held}, {8'h1C, 2'b00, 8'h04});
    drain();

    // Random traffic against the model, with occasional long idle gaps.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat (TMO + 5) step(1'b0, 8'h00, 1'b0, 1'b0);
      end else begin
        r = $urandom_range(0, 19);
        b = (r < 16) ? pool[r] : 8'($urandom);
        step($urandom_range(0, 1) == 1, b, $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream of the PS/2 keyboard receiver (one 8-bit scan code per `code_valid` pulse) and turns Set-2 prefix sequences into complete key events. Events go into a small show-ahead event FIFO read by the game logic. The block also maintains a live bitmap of the game-control keys that are held down. It sits between the PS/2 receiver and the game-console controller.

## Interface
- `DEPTH`, 8: event FIFO entries; power of two, 2..64.
- `TIMEOUT_CYC`, 2_000_000: idle cycles after a prefix byte before the sequence is abandoned; 20 ms at 100 MHz.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `code_in` in 8: scan code from the receiver; sampled only when `code_valid`=1.
- `code_valid` in 1: one-cycle strobe per received byte.
- `ev_code` out 8: head-of-FIFO base scan code.
- `ev_ext` out 1: head event had an E0 prefix.
- `ev_brk` out 1: head event is a release (F0 seen).
- `ev_valid` out 1: FIFO non-empty.
- `ev_ready` in 1: consumer pop; a pop occurs when `ev_valid & ev_ready`.
- `keys_held` out 8: game-key bitmap.
  - bit0 up: W=1D, E0 75
  - bit1 down: S=1B, E0 72
  - bit2 left: A=1C, E0 6B
  - bit3 right: D=23, E0 74
  - bit4 fire: 29
  - bit5 start: 5A or E0 5A
  - bit6 back: 76
  - bit7 pause: 4D, or the E1 sequence
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `clr_ovf` in 1: synchronous clear of `overflow`.

## Operation
- Prefix FSM states:
  - IDLE: 00, AA, EE, FA, FC, FE and FF are discarded. E0 goes to EXT. F0 goes to BRK. E1 goes to SKIP with skip count 7. Any other byte completes a make event with ext=0.
  - EXT: F0 goes to EXTBRK. E0 stays in EXT. Any other byte completes a make event with ext=1.
  - BRK: any byte except E0/F0 completes a break event with ext=0. E0/F0 here abandon the sequence and return to IDLE.
  - EXTBRK: any byte except E0/F0 completes a break event with ext=1. E0/F0 abandon the sequence and return to IDLE.
  - SKIP: each byte decrements the skip count. When the count reaches 0, emit event {E1, ext=0, brk=0}, pulse pause for exactly one cycle, and return to IDLE.
- Completed event: enqueue {ext, brk, code}. In the same cycle update `keys_held`: a make sets the mapped bit, a break clears it. Unmapped codes enqueue only.
- Aliased keys: W and E0 75 share bit0; a break of either clears the bit. Other aliased pairs behave the same way.
- Timeout: in EXT, BRK, EXTBRK or SKIP, the counter runs on cycles without `code_valid` and resets on each byte. On reaching `TIMEOUT_CYC`-1, go to IDLE with no event.
- FIFO:
  - A push while full (and no simultaneous pop) is dropped and sets `overflow`.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop in the same cycle when empty: the push succeeds, and `ev_valid` rises the next cycle.
- `clr_ovf` and a new overflow in the same cycle: `overflow` stays 1.

## Timing
- Reset values: `ev_valid`=0; `ev_code`, `ev_ext`, `ev_brk`=0; `keys_held`=0; `overflow`=0. FSM in IDLE, timeout counter 0, FIFO empty.
- Reset asserted mid-sequence discards any partial prefix and all queued events.
- Latency from the final byte's `code_valid` edge:
  - `keys_held` updated 1 cycle later.
  - `ev_valid`/head fields valid 1 cycle later if the FIFO was empty.
- Head fields are stable while `ev_valid`=1 and no pop occurs. Head fields are don't-care while `ev_valid`=0.
- `code_valid` on consecutive cycles is supported: one byte per cycle, no back-pressure upstream.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined: a make event for a mapped key whose bit is already set is not enqueued (typematic repeat suppressed). `keys_held` is unchanged. Unmapped keys and breaks are unaffected.
- `PS2_TYPEMATIC_FILTER_EN` not defined: every make is enqueued, including repeats.

## Structure
- `ps2_pkg`:
  - prefix constants (E0, E1, F0) and the discard-code list
  - key-map codes and bitmap bit indices
  - FSM state enum
  - event width constant (10)
- Sub-module `ps2_event_fifo`: parameterised `DEPTH`, show-ahead, width 10, with full/empty outputs. It is instantiated once.

## Test plan
- Bytes 1D; then F0, 1D; `ev_ready`=1 → events {1D,0,0} then {1D,0,1}; `keys_held[0]` is 1 then 0.
- Bytes E0, 74, E0, F0, 74 → events {74,1,0} then {74,1,1}; `keys_held[3]` goes 1 then 0.
- Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,0}; `keys_held[7]` high for one cycle; FSM back in IDLE.
- Byte E0, then no bytes for `TIMEOUT_CYC` cycles, then 1C → event {1C,0,0} (not extended).
- `ev_ready`=0 and 9 make codes with `DEPTH`=8 → 8 events queued, `overflow`=1. Pop all 8 in order, then `clr_ovf` → `overflow`=0.
- Bytes 29, 29, 29 → 3 events without `PS2_TYPEMATIC_FILTER_EN`, 1 event with it; `keys_held[4]`=1 in both builds.
